// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the decoupled instruction-fetch front end.
// State encodings, buffer entry layout, and the fetch alignment check.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_TRAP_PEND = 2'd1,
      ST_IDLE      = 2'd2
   } fetch_state_e;

   localparam int          ENTRY_W            = 65;
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        trap;
   } fetch_entry_t;

   function automatic logic imem_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush and simultaneous push/pop.
// A push during a flush lands as the sole entry.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign head    = mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // Full FIFO may still accept when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         if (push) begin
            mem[0] <= push_data;
            wr_ptr <= AW'(1);
            count  <= CW'(1);
         end else begin
            wr_ptr <= '0;
            count  <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: credit-limited requests to a variable-latency
// in-order memory, buffered responses, and redirect / misaligned-trap handling.
//
// state        | meaning
// ST_RUN       | normal fetch, requests issued while credit remains
// ST_TRAP_PEND | misaligned trap entry buffered, stale responses drained
// ST_IDLE      | trap delivered, wait for a redirect
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_rdata,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_inst,
   output logic        o_if_trap
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e  state;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   credit_used;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_push;
   logic [ENTRY_W-1:0] fifo_wdata;
   logic [ENTRY_W-1:0] fifo_head;
   fetch_entry_t  head_e;
   logic          req_fire;
   logic          rsp_accept;
   logic          rsp_push;
   logic          if_fire;
   logic          redirect_trap;

   // Words already requested but not yet returned still hold a buffer slot,
   // except those that will be discarded.
   assign credit_used = {1'b0, outstanding - drop_cnt} + {1'b0, fifo_count};

   assign o_imem_req_valid = !i_rst && (state == ST_RUN) && !i_redirect_valid &&
                             !fifo_full && (outstanding < CW'(FIFO_DEPTH)) &&
                             (credit_used < (CW + 1)'(FIFO_DEPTH));
   assign o_imem_req_addr  = fetch_pc;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;

   assign rsp_accept    = i_imem_rsp_valid && (outstanding != '0);
   assign rsp_push      = rsp_accept && (drop_cnt == '0) && !i_redirect_valid;
   assign redirect_trap = i_redirect_valid && !imem_aligned(i_redirect_pc);

   assign fifo_push  = i_redirect_valid ? redirect_trap : rsp_push;
   assign fifo_wdata = i_redirect_valid ? {i_redirect_pc, 32'h0, 1'b1}
                                        : {rsp_pc, i_imem_rsp_rdata, 1'b0};

   assign head_e     = fetch_entry_t'(fifo_head);
   assign o_if_valid = !i_rst && !fifo_empty && !i_redirect_valid;
   assign o_if_pc    = head_e.pc;
   assign o_if_inst  = head_e.inst;
   assign o_if_trap  = o_if_valid && head_e.trap;
   assign if_fire    = o_if_valid && i_if_ready;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .flush     (i_redirect_valid),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (if_fire),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_RUN;
         fetch_pc    <= RESET_ADDR;
         rsp_pc      <= RESET_ADDR;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (i_redirect_valid) begin
         fetch_pc    <= i_redirect_pc;
         rsp_pc      <= i_redirect_pc;
         outstanding <= outstanding - CW'(rsp_accept);
         drop_cnt    <= outstanding - CW'(rsp_accept);
         state       <= redirect_trap ? ST_TRAP_PEND : ST_RUN;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
         if (rsp_accept && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
         end
         if (rsp_push) begin
            rsp_pc <= rsp_pc + 32'd4;
         end
         if ((state == ST_TRAP_PEND) && if_fire) begin
            state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: fixed-latency in-order memory model, in-order stream
// scoreboard, table of fetch vectors and directed redirect/trap/reset sequences.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready = 1'b1;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_rsp_valid = 1'b0;
   logic [31:0] i_imem_rsp_rdata = 32'h0;
   logic        i_redirect_valid = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic        o_if_valid;
   logic        i_if_ready = 1'b0;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_inst;
   logic        o_if_trap;

   fetch_stage #(
      .RESET_ADDR (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .i_clk            (clk),
      .i_rst            (i_rst),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_req_addr  (o_imem_req_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_rdata (i_imem_rsp_rdata),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_if_valid       (o_if_valid),
      .i_if_ready       (i_if_ready),
      .o_if_pc          (o_if_pc),
      .o_if_inst        (o_if_inst),
      .o_if_trap        (o_if_trap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        redir;
      logic [31:0] start;
      int          lat;
      logic [3:0]  mask;
      int          n;
      logic [31:0] last_pc;
      logic [31:0] last_inst;
   } vec_t;

   pend_t       mq[$];
   int          cyc = 0;
   int          mem_lat = 1;
   int          checks = 0;
   int          failures = 0;
   int          req_count = 0;
   int          delivered = 0;
   logic        stream_en = 1'b0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] first_req_addr = 32'h0;
   logic [31:0] last_req_addr = 32'h0;
   logic [31:0] last_pc = 32'h0;
   logic [31:0] last_inst = 32'h0;
   vec_t        vecs[4];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      pend_t p;
      @(negedge clk);
      if (i_rst) begin
         mq.delete();
      end else begin
         if (o_imem_req_valid && i_imem_req_ready) begin
            p.addr = o_imem_req_addr;
            p.due  = cyc + mem_lat;
            mq.push_back(p);
            if (req_count == 0) first_req_addr = o_imem_req_addr;
            last_req_addr = o_imem_req_addr;
            req_count++;
         end
         if (stream_en && o_if_valid && i_if_ready) begin
            chk("stream_pc", o_if_pc, exp_pc);
            chk("stream_inst", o_if_inst, mem_word(exp_pc));
            chk("stream_trap", {31'h0, o_if_trap}, 32'h0);
            last_pc   = o_if_pc;
            last_inst = o_if_inst;
            exp_pc    = exp_pc + 32'd4;
            delivered++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         i_imem_rsp_valid = 1'b1;
         i_imem_rsp_rdata = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         i_imem_rsp_valid = 1'b0;
         i_imem_rsp_rdata = 32'h0;
      end
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_redirect_valid = 1'b0;
      i_if_ready = 1'b0;
      step();
      step();
      chk("rst_req_valid", {31'h0, o_imem_req_valid}, 32'h0);
      chk("rst_if_valid", {31'h0, o_if_valid}, 32'h0);
      chk("rst_if_trap", {31'h0, o_if_trap}, 32'h0);
      i_rst = 1'b0;
      #1;
      chk("rst_first_req_valid", {31'h0, o_imem_req_valid}, 32'h1);
      chk("rst_first_req_addr", o_imem_req_addr, 32'h0);
      req_count = 0;
      delivered = 0;
      exp_pc = 32'h0;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      i_redirect_valid = 1'b1;
      i_redirect_pc = pc;
      exp_pc = pc;
      req_count = 0;
      delivered = 0;
      step();
      i_redirect_valid = 1'b0;
      #1;
   endtask

   task automatic run_until(input int n, input int budget, input logic [3:0] mask);
      int b;
      b = budget;
      while (delivered < n && b > 0) begin
         i_if_ready = mask[cyc % 4];
         step();
         b--;
      end
      chk("delivered_count", delivered, n);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0000, 1, 4'b1111, 3, 32'h0000_0008, 32'hC0DE_0008};
      vecs[1] = '{1'b1, 32'h0000_1000, 2, 4'b0101, 5, 32'h0000_1010, 32'hC0DE_1010};
      vecs[2] = '{1'b1, 32'hFFFF_FFF8, 1, 4'b1111, 4, 32'h0000_0004, 32'hC0DE_0004};
      vecs[3] = '{1'b1, 32'h0000_2000, 5, 4'b1000, 4, 32'h0000_200C, 32'hC0DE_200C};

      for (int i = 0; i < 4; i++) begin
         mem_lat = vecs[i].lat;
         stream_en = 1'b1;
         if (vecs[i].redir) redirect_to(vecs[i].start);
         else do_reset();
         run_until(vecs[i].n, 300, vecs[i].mask);
         chk("vec_last_pc", last_pc, vecs[i].last_pc);
         chk("vec_last_inst", last_inst, vecs[i].last_inst);
      end

      // Decode stalled, latency 3: credit caps in-flight plus buffered at two.
      mem_lat = 3;
      do_reset();
      stream_en = 1'b1;
      repeat (10) step();
      chk("stall_req_count", req_count, 2);
      chk("stall_last_req", last_req_addr, 32'h4);
      chk("stall_req_low", {31'h0, o_imem_req_valid}, 32'h0);
      chk("stall_head_valid", {31'h0, o_if_valid}, 32'h1);
      chk("stall_head_pc", o_if_pc, 32'h0);
      run_until(6, 200, 4'b1111);

      // Two requests in flight, then redirect: both late words must vanish.
      mem_lat = 4;
      i_if_ready = 1'b1;
      redirect_to(32'h10);
      for (int b = 0; b < 20 && req_count < 2; b++) step();
      chk("inflight_reqs", req_count, 2);
      chk("inflight_stall", {31'h0, o_imem_req_valid}, 32'h0);
      redirect_to(32'h100);
      run_until(3, 200, 4'b1111);
      chk("redir_first_req", first_req_addr, 32'h100);

      // Misaligned redirect produces a single trap entry, then idles.
      mem_lat = 2;
      stream_en = 1'b0;
      i_if_ready = 1'b0;
      redirect_to(32'h102);
      chk("trap_valid", {31'h0, o_if_valid}, 32'h1);
      chk("trap_pc", o_if_pc, 32'h102);
      chk("trap_inst", o_if_inst, 32'h0);
      chk("trap_flag", {31'h0, o_if_trap}, 32'h1);
      chk("trap_no_req", {31'h0, o_imem_req_valid}, 32'h0);
      i_if_ready = 1'b1;
      step();
      chk("idle_valid", {31'h0, o_if_valid}, 32'h0);
      chk("idle_trap", {31'h0, o_if_trap}, 32'h0);
      repeat (5) step();
      chk("idle_req_count", req_count, 0);
      chk("idle_valid_late", {31'h0, o_if_valid}, 32'h0);
      stream_en = 1'b1;
      redirect_to(32'h200);
      run_until(2, 200, 4'b1111);
      chk("resume_first_req", first_req_addr, 32'h200);

      // Redirect coinciding with a response and a decode handshake.
      mem_lat = 1;
      i_if_ready = 1'b1;
      redirect_to(32'h300);
      begin
         int found;
         found = 0;
         for (int b = 0; b < 30 && found == 0; b++) begin
            if (i_imem_rsp_valid && o_if_valid) found = 1;
            else step();
         end
         chk("collide_setup", found, 1);
      end
      i_redirect_valid = 1'b1;
      i_redirect_pc = 32'h400;
      #1;
      chk("collide_if_valid", {31'h0, o_if_valid}, 32'h0);
      chk("collide_req_valid", {31'h0, o_imem_req_valid}, 32'h0);
      exp_pc = 32'h400;
      req_count = 0;
      delivered = 0;
      step();
      i_redirect_valid = 1'b0;
      run_until(3, 200, 4'b1111);
      chk("collide_first_req", first_req_addr, 32'h400);

      // Reset with requests outstanding.
      mem_lat = 3;
      i_if_ready = 1'b0;
      redirect_to(32'h40);
      for (int b = 0; b < 20 && req_count < 2; b++) step();
      chk("prerst_reqs", req_count, 2);
      do_reset();
      run_until(2, 200, 4'b1111);
      chk("postrst_first_req", first_req_addr, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
